// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU signal bundle for alu_arbiter
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_sel;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_carryout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready, alu_result, alu_carryout,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err,
    output alu_a, alu_b, alu_sel
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready, alu_result, alu_carryout,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err,
    input  alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned ALU_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        gnt_any;
  logic        gnt_id;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;
  logic [3:0]  gnt_sel;
  logic [3:0]  lat_m1;
  logic        op_illegal;
  logic        div_zero;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_any    = bus.req0_valid | bus.req1_valid;
    gnt_id     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    gnt_a      = gnt_id ? bus.req1_a   : bus.req0_a;
    gnt_b      = gnt_id ? bus.req1_b   : bus.req0_b;
    gnt_sel    = gnt_id ? bus.req1_sel : bus.req0_sel;
    op_illegal = (gnt_sel >= 4'd10);
    div_zero   = (gnt_sel == 4'd9) && (gnt_b == 32'd0);
    case (gnt_sel)
      4'd8:    lat_m1 = 4'(MUL_CYCLES - 1);
      4'd9:    lat_m1 = 4'(DIV_CYCLES - 1);
      default: lat_m1 = 4'(ALU_CYCLES - 1);
    endcase
  end

  assign bus.req0_ready = (state == IDLE) && gnt_any && !gnt_id;
  assign bus.req1_ready = (state == IDLE) && gnt_any &&  gnt_id;
  assign bus.rsp_valid  = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nxt = (op_illegal || div_zero) ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only loaded on a grant, so they stay put through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= 4'd0;
      last_grant     <= 1'b1;
      bus.alu_a      <= 32'd0;
      bus.alu_b      <= 32'd0;
      bus.alu_sel    <= 4'd0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= 32'd0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            bus.alu_a   <= gnt_a;
            bus.alu_b   <= gnt_b;
            bus.alu_sel <= gnt_sel;
            bus.rsp_id  <= gnt_id;
            last_grant  <= gnt_id;
            cnt         <= lat_m1;
            if (op_illegal) begin
              bus.rsp_result <= 32'd0;
              bus.rsp_carry  <= 1'b0;
              bus.rsp_err    <= 1'b1;
            end else if (div_zero) begin
              bus.rsp_result <= 32'hFFFF_FFFF;
              bus.rsp_carry  <= 1'b1;
              bus.rsp_err    <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_carry  <= bus.alu_carryout;
            bus.rsp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized scoreboard bench for alu_arbiter
module tb_alu_arbiter;
  localparam int MUL_C = 4;
  localparam int DIV_C = 8;
  localparam int ALU_C = 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(
    .MUL_CYCLES(MUL_C),
    .DIV_CYCLES(DIV_C),
    .ALU_CYCLES(ALU_C)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  op_t         q0[$];
  op_t         q1[$];
  logic        v_d[2];
  logic [31:0] a_d[2];
  logic [31:0] b_d[2];
  logic [3:0]  s_d[2];
  logic        rr_d;
  int          rsp_mode;
  bit          gap_en;
  int          checks = 0;
  int          errors = 0;
  int          pushed = 0;

  assign bus.req0_valid = v_d[0];
  assign bus.req0_a     = a_d[0];
  assign bus.req0_b     = b_d[0];
  assign bus.req0_sel   = s_d[0];
  assign bus.req1_valid = v_d[1];
  assign bus.req1_a     = a_d[1];
  assign bus.req1_b     = b_d[1];
  assign bus.req1_sel   = s_d[1];
  assign bus.rsp_ready  = rr_d;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return a * b;
      4'd9: return (b == 32'd0) ? 32'h1234_5678 : a / b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU; garbage for illegal ops and divide by zero must never reach rsp_result.
  assign bus.alu_result   = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
  assign bus.alu_carryout = bus.alu_result[31];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    op_t o;
    o.a   = a;
    o.b   = b;
    o.sel = s;
    if (n == 0) q0.push_back(o);
    else q1.push_back(o);
    pushed++;
  endtask

  bit          busy;
  bit          last_g;
  bit          took[2];
  logic [31:0] cur_a;
  logic [31:0] cur_b;
  logic [3:0]  cur_s;
  int          ncyc = 0;
  int          hs_cyc;
  int          first_id;
  int          nrsp = 0;
  bit          exp_id;
  logic [31:0] exp_res;
  bit          exp_carry;
  bit          exp_err;
  int          exp_lat;

  // Transaction-level reference: one op in flight, round-robin on ties, fixed latency per op.
  always @(negedge clk) begin
    logic [1:0] exp_r;
    bit g;
    ncyc++;
    took[0] = 1'b0;
    took[1] = 1'b0;
    if (!rst_n) begin
      busy     = 1'b0;
      last_g   = 1'b1;
      cur_a    = 32'd0;
      cur_b    = 32'd0;
      cur_s    = 4'd0;
      first_id = -1;
    end else begin
      check("alu_a", 64'(bus.alu_a), 64'(cur_a));
      check("alu_b", 64'(bus.alu_b), 64'(cur_b));
      check("alu_sel", 64'(bus.alu_sel), 64'(cur_s));
      if (busy) begin
        check("ready_busy", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        check("rsp_valid", 64'(bus.rsp_valid), 64'((ncyc - hs_cyc) >= exp_lat));
        if (bus.rsp_valid) begin
          check("rsp_id", 64'(bus.rsp_id), 64'(exp_id));
          check("rsp_result", 64'(bus.rsp_result), 64'(exp_res));
          check("rsp_carry", 64'(bus.rsp_carry), 64'(exp_carry));
          check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
          if (bus.rsp_ready) begin
            busy = 1'b0;
            nrsp++;
          end
        end
      end else begin
        check("rsp_idle", 64'(bus.rsp_valid), 64'd0);
        if (bus.req0_valid && bus.req1_valid) exp_r = last_g ? 2'b01 : 2'b10;
        else exp_r = {bus.req1_valid, bus.req0_valid};
        check("grant", 64'({bus.req1_ready, bus.req0_ready}), 64'(exp_r));
        if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
          g = bus.req1_valid && bus.req1_ready;
          took[g] = 1'b1;
          if (first_id < 0) first_id = int'(g);
          cur_a  = g ? bus.req1_a : bus.req0_a;
          cur_b  = g ? bus.req1_b : bus.req0_b;
          cur_s  = g ? bus.req1_sel : bus.req0_sel;
          last_g = g;
          exp_id = g;
          busy   = 1'b1;
          hs_cyc = ncyc;
          if (cur_s >= 4'd10) begin
            exp_res = 32'd0; exp_carry = 1'b0; exp_err = 1'b1; exp_lat = 1;
          end else if (cur_s == 4'd9 && cur_b == 32'd0) begin
            exp_res = 32'hFFFF_FFFF; exp_carry = 1'b1; exp_err = 1'b1; exp_lat = 1;
          end else begin
            exp_res   = alu_fn(cur_a, cur_b, cur_s);
            exp_carry = exp_res[31];
            exp_err   = 1'b0;
            exp_lat   = (cur_s == 4'd8 ? MUL_C : (cur_s == 4'd9 ? DIV_C : ALU_C)) + 1;
          end
        end
      end
    end
  end

  // Requester and consumer drivers; idle requesters wiggle their payload every cycle.
  initial begin
    op_t o;
    v_d[0] = 1'b0; v_d[1] = 1'b0;
    a_d[0] = 32'd0; a_d[1] = 32'd0;
    b_d[0] = 32'd0; b_d[1] = 32'd0;
    s_d[0] = 4'd0; s_d[1] = 4'd0;
    rr_d   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       rr_d = 1'b1;
        1:       rr_d = 1'($urandom_range(0, 1));
        default: rr_d = 1'b0;
      endcase
      for (int n = 0; n < 2; n++) begin
        if (v_d[n] && took[n]) v_d[n] = 1'b0;
        if (!v_d[n]) begin
          a_d[n] = $urandom;
          b_d[n] = $urandom;
          s_d[n] = 4'($urandom_range(0, 15));
          if (!(gap_en && $urandom_range(0, 2) == 0)) begin
            if (n == 0 && q0.size() > 0) begin
              o = q0.pop_front();
              v_d[n] = 1'b1; a_d[n] = o.a; b_d[n] = o.b; s_d[n] = o.sel;
            end else if (n == 1 && q1.size() > 0) begin
              o = q1.pop_front();
              v_d[n] = 1'b1; a_d[n] = o.a; b_d[n] = o.b; s_d[n] = o.sel;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || v_d[0] || v_d[1] || busy) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(q0.size() + q1.size() + int'(v_d[0]) + int'(v_d[1]) + int'(busy)), 64'd0);
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    rsp_mode = 0;
    gap_en   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_carry", 64'(bus.rsp_carry), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_alu_sel", 64'(bus.alu_sel), 64'd0);
    check("rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    push_op(0, 32'd5, 32'd3, 4'd1);
    push_op(1, 32'd6, 32'd7, 4'd8);
    push_op(0, 32'd5, 32'd3, 4'd1);
    wait_idle(200);
    check("tie_first_id", 64'(first_id), 64'd0);

    push_op(0, 32'd32, 32'd32, 4'd0);
    wait_idle(100);

    rsp_mode = 2;
    push_op(0, 32'd1, 32'd2, 4'd1);
    push_op(1, 32'd7, 32'd7, 4'd4);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    repeat (5) @(negedge clk);
    rsp_mode = 0;
    wait_idle(100);

    push_op(1, 32'd100, 32'd0, 4'd9);
    push_op(0, 32'd9, 32'd9, 4'd12);
    push_op(1, 32'd100, 32'd7, 4'd9);
    wait_idle(200);

    push_op(0, 32'd1000, 32'd3, 4'd9);
    wait_idle(100);

    push_op(0, 32'd3, 32'd5, 4'd8);
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_alu_a", 64'(bus.alu_a), 64'd0);
    check("mid_alu_sel", 64'(bus.alu_sel), 64'd0);
    push_op(0, 32'd1, 32'd1, 4'd0);
    push_op(1, 32'd2, 32'd2, 4'd0);
    wait_idle(100);
    check("mid_tie_id", 64'(first_id), 64'd0);

    gap_en   = 1'b1;
    rsp_mode = 1;
    for (int i = 0; i < 60; i++) begin
      for (int n = 0; n < 2; n++) begin
        push_op(n, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                4'($urandom_range(0, 11)));
      end
    end
    wait_idle(20000);
    check("rsp_count", 64'(nrsp), 64'(pushed - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
